alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DEPTH, default 2 (fixed), number of buffered issue entries.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  upstream (decode) presents an operation.
REQ-005 in_ready  output  1  registered; block can accept an operation this cycle.
REQ-006 aluOp  input  2  00 add, 01 sub, 10 R-type by funct, 11 immediate by opcode.
REQ-007 funct  input  6  R-type function field.
REQ-008 opcode  input  6  I-type opcode field.
REQ-009 opA, opB  input  32 each  source operands.
REQ-010 shamtIn  input  5  shift amount.
REQ-011 flush  input  1  discard all buffered entries.
REQ-012 out_valid  output  1  ALU-side operation valid.
REQ-013 out_ready  input  1  EX stage consumes the head entry.
REQ-014 aluControlInput  output  4  ALU select code of head entry.
REQ-015 firstOperand, secondOperand  output  32 each  head operands.
REQ-016 shamt  output  5  head shift amount.
REQ-017 illegal  output  1  registered one-cycle pulse for an undecodable accepted operation.

Function
REQ-018 Accept occurs when in_valid && in_ready; transfer occurs when out_valid && out_ready.
REQ-019 Decode: aluOp 00->0010, 01->0110.
REQ-020 aluOp 10 funct: 100000/100001->0010, 100010/100011->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111, 101011->1011, 000000->0011, 000010->0100.
REQ-021 aluOp 11 opcode: 001000/001001->0010, 001100->0000, 001101->0001, 001010->0111, 001011->1011.
REQ-022 Any other funct/opcode: entry is not stored, illegal pulses the next cycle, in_ready unaffected.
REQ-023 Operands and shamtIn are stored unmodified; no sign/zero extension performed here.
REQ-024 FSM states EMPTY, ONE, TWO (entry count); outputs always driven from head register.
REQ-025 EMPTY: legal accept -> ONE.
REQ-026 ONE: accept without transfer -> TWO; transfer without accept -> EMPTY; both -> ONE, new entry becomes head next cycle.
REQ-027 TWO: transfer -> ONE, second entry moves to head; no accept possible.
REQ-028 in_ready = 1 in EMPTY and ONE, 0 in TWO; derived from registered state only (no combinational out_ready->in_ready path).
REQ-029 Latency: legal accept in EMPTY produces out_valid next cycle; throughput one op/cycle with out_ready held high.
REQ-030 Head contents stable while out_valid && !out_ready.
REQ-031 flush: next state EMPTY, overrides simultaneous accept and transfer; illegal still pulses for an illegal op presented that cycle.
REQ-032 Illegal op presented in TWO (in_ready=0) is not accepted and raises no pulse.

Reset
REQ-033 rst_n low at clk edge: state EMPTY, out_valid 0, illegal 0, aluControlInput 0010, operands/shamt 0, in_ready 1 in the following cycle.
REQ-034 Reset mid-operation discards all entries; no transfer reported after reset edge.

Structure
REQ-035 Shared package holds ALU code constants (AND, OR, ADD, SLL, SRL, SUB, SLT, SLTU, NOR), aluOp encodings, funct/opcode constants; ALU consumes the same constants.
REQ-036 One sub-module alu_decode: purely combinational aluOp/funct/opcode -> {code, legal}.

Verification
REQ-037 Reset then aluOp=10 funct=100010 opA=7 opB=3, out_ready=1 -> next cycle out_valid=1, code 0110, operands 7/3.
REQ-038 out_ready=0, two accepts (funct 100100, then 100101) -> in_ready 0 after second; release out_ready -> codes 0000 then 0001 in order.
REQ-039 Back-to-back 8 ops with out_ready=1 -> 8 transfers in 8 consecutive cycles, order preserved.
REQ-040 aluOp=10 funct=111111 in EMPTY -> illegal=1 for one cycle, out_valid stays 0.
REQ-041 State TWO, assert flush with out_ready=1 -> next cycle out_valid 0, in_ready 1, no transfer.
REQ-042 aluOp=11 opcode=001011 opA=-1 opB=1 -> code 1011; rst_n low while TWO -> out_valid 0 next cycle.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared ALU constants, field encodings and issue-buffer types.
// The ALU datapath imports this package too, so both sides agree on the select codes.
package alu_issue_pkg;

    // ALU select codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // aluOp encodings from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // R-type funct fields
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;

    // I-type opcodes
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  shamt;
    } issue_entry_t;

    localparam issue_entry_t RESET_ENTRY = '{code: ALU_ADD, op_a: 32'd0, op_b: 32'd0, shamt: 5'd0};

    function automatic int entry_count(input issue_state_t s);
        case (s)
            EMPTY:   return 0;
            ONE:     return 1;
            default: return 2;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational ALU control decode: aluOp/funct/opcode to a select code plus a legal flag.
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [3:0] code,
    output logic       legal
);

    always_comb begin
        code  = ALU_ADD;
        legal = 1'b0;
        case (aluOp)
            ALUOP_ADD: begin
                code  = ALU_ADD;
                legal = 1'b1;
            end
            ALUOP_SUB: begin
                code  = ALU_SUB;
                legal = 1'b1;
            end
            ALUOP_RTYPE: begin
                legal = 1'b1;
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: code = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: code = ALU_SUB;
                    FUNCT_AND:             code = ALU_AND;
                    FUNCT_OR:              code = ALU_OR;
                    FUNCT_NOR:             code = ALU_NOR;
                    FUNCT_SLT:             code = ALU_SLT;
                    FUNCT_SLTU:            code = ALU_SLTU;
                    FUNCT_SLL:             code = ALU_SLL;
                    FUNCT_SRL:             code = ALU_SRL;
                    default:               legal = 1'b0;
                endcase
            end
            default: begin
                legal = 1'b1;
                case (opcode)
                    OPC_ADDI, OPC_ADDIU: code = ALU_ADD;
                    OPC_ANDI:            code = ALU_AND;
                    OPC_ORI:             code = ALU_OR;
                    OPC_SLTI:            code = ALU_SLT;
                    OPC_SLTIU:           code = ALU_SLTU;
                    default:             legal = 1'b0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Two-entry issue buffer between decode and the ALU; decodes the ALU select code on entry
// and presents the oldest entry (head register) to the EX stage.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  aluOp,
    input  logic [5:0]  funct,
    input  logic [5:0]  opcode,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  shamtIn,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  aluControlInput,
    output logic [31:0] firstOperand,
    output logic [31:0] secondOperand,
    output logic [4:0]  shamt,
    output logic        illegal
);

    issue_state_t state;
    issue_state_t next_state;
    issue_entry_t head;
    issue_entry_t second;
    issue_entry_t incoming;

    logic [3:0] dec_code;
    logic       dec_legal;
    logic       accept;
    logic       legal_accept;
    logic       transfer;

    alu_decode u_decode (
        .aluOp  (aluOp),
        .funct  (funct),
        .opcode (opcode),
        .code   (dec_code),
        .legal  (dec_legal)
    );

    assign incoming     = '{code: dec_code, op_a: opA, op_b: opB, shamt: shamtIn};
    assign accept       = in_valid && in_ready;
    assign legal_accept = accept && dec_legal;
    assign transfer     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (legal_accept) next_state = ONE;
                end
                ONE: begin
                    if (legal_accept && !transfer)      next_state = TWO;
                    else if (!legal_accept && transfer) next_state = EMPTY;
                end
                TWO: begin
                    if (transfer) next_state = ONE;
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // Handshake outputs depend only on the state register, so out_ready never reaches in_ready.
    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = (entry_count(state) < DEPTH);
    end

    // Flush leaves the head untouched; out_valid drops, so its stale contents are harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head    <= RESET_ENTRY;
            second  <= RESET_ENTRY;
            illegal <= 1'b0;
        end else begin
            illegal <= accept && !dec_legal;
            if (!flush) begin
                case (state)
                    EMPTY: begin
                        if (legal_accept) head <= incoming;
                    end
                    ONE: begin
                        if (legal_accept && transfer) head   <= incoming;
                        else if (legal_accept)        second <= incoming;
                    end
                    TWO: begin
                        if (transfer) head <= second;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign aluControlInput = head.code;
    assign firstOperand    = head.op_a;
    assign secondOperand   = head.op_b;
    assign shamt           = head.shamt;

endmodule
